// File: rtl/macc_seq.sv
// macc_seq: job sequencer driving an external MACC.
// One job = cfg handshake, N operand pairs, one held result.
module macc_seq #(
  parameter int OP_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 cfg_square,
  input  logic                 cfg_bias_en,
  input  logic [ACC_WIDTH-1:0] cfg_bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_WIDTH-1:0]  in_op_0,
  input  logic [OP_WIDTH-1:0]  in_op_1,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 abort,
  output logic                 err,
  output logic                 busy,
  output logic                 macc_enable,
  output logic                 macc_clear,
  output logic [2:0]           macc_op_code,
  output logic [OP_WIDTH-1:0]  macc_op_0,
  output logic [OP_WIDTH-1:0]  macc_op_1,
  output logic [ACC_WIDTH-1:0] macc_op_add
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD,
    ABORT
  } state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 first;
  logic [1:0]           drain_cnt;
  logic [1:0]           abort_cnt;
  logic                 square_q;
  logic                 bias_en_q;
  logic [ACC_WIDTH-1:0] bias_q;

  // Handshakes decode from state; abort masks them in the same cycle.
  always_comb begin
    cfg_ready   = (state == IDLE);
    in_ready    = (state == RUN) && !abort;
    out_valid   = (state == HOLD) && !abort;
    busy        = (state != IDLE);
    macc_enable = in_valid && in_ready;
    macc_clear  = (state == ABORT) && (abort_cnt == 2'd2);
    macc_op_0   = in_op_0;
    macc_op_1   = in_op_1;
    macc_op_add = bias_q;
    macc_op_code = 3'b000;
    if (state == RUN) begin
      if (first)
        macc_op_code = {bias_en_q, 1'b0, square_q};
      else
        macc_op_code = {1'b0, 1'b1, square_q};
    end
  end

  // Job FSM: count elements, wait out MACC latency, hold result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      first     <= 1'b0;
      drain_cnt <= 2'd0;
      abort_cnt <= 2'd0;
      square_q  <= 1'b0;
      bias_en_q <= 1'b0;
      bias_q    <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            square_q  <= cfg_square;
            bias_en_q <= cfg_bias_en;
            bias_q    <= cfg_bias;
            remaining <= cfg_len;
            if (cfg_len == '0) begin
              err <= 1'b1;
            end else begin
              state <= RUN;
              first <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state     <= ABORT;
            abort_cnt <= 2'd2;
          end else if (in_valid) begin
            remaining <= remaining - LEN_WIDTH'(1);
            first     <= 1'b0;
            if (remaining == LEN_WIDTH'(1)) begin
              state     <= DRAIN;
              drain_cnt <= 2'd2;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state     <= ABORT;
            abort_cnt <= 2'd2;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
            if (drain_cnt == 2'd1)
              state <= HOLD;
          end
        end
        HOLD: begin
          if (abort) begin
            state     <= ABORT;
            abort_cnt <= 2'd2;
          end else if (out_ready) begin
            state <= IDLE;
          end
        end
        ABORT: begin
          abort_cnt <= abort_cnt - 2'd1;
          if (abort_cnt == 2'd0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_macc_seq.sv
// tb_macc_seq: directed jobs, per-cycle control checks,
// behavioural MACC accumulator checked against plain sums.
module tb_macc_seq;
  localparam int OW = 16;
  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [LW-1:0] cfg_len;
  logic          cfg_square;
  logic          cfg_bias_en;
  logic [AW-1:0] cfg_bias;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_op_0;
  logic [OW-1:0] in_op_1;
  logic          out_valid;
  logic          out_ready;
  logic          abort;
  logic          err;
  logic          busy;
  logic          macc_enable;
  logic          macc_clear;
  logic [2:0]    macc_op_code;
  logic [OW-1:0] macc_op_0;
  logic [OW-1:0] macc_op_1;
  logic [AW-1:0] macc_op_add;

  always #5 clk = ~clk;

  macc_seq #(.OP_WIDTH(OW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_len(cfg_len), .cfg_square(cfg_square),
    .cfg_bias_en(cfg_bias_en), .cfg_bias(cfg_bias),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op_0(in_op_0), .in_op_1(in_op_1),
    .out_valid(out_valid), .out_ready(out_ready),
    .abort(abort), .err(err), .busy(busy),
    .macc_enable(macc_enable), .macc_clear(macc_clear),
    .macc_op_code(macc_op_code),
    .macc_op_0(macc_op_0), .macc_op_1(macc_op_1),
    .macc_op_add(macc_op_add)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic          chk_en = 1'b0;
  logic [9:0]    exp_ctl;
  logic [AW-1:0] exp_bias;
  logic [AW-1:0] exp_res;
  logic          res_en = 1'b0;
  logic [AW-1:0] acc = '0;

  logic [OW-1:0] a [0:7];
  logic [OW-1:0] b [0:7];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s t=%0t act=%h req=%h",
                  nm, $time, act, req);
  endtask

  // expected control vector for the current cycle
  task automatic ex(input bit cr, ir, ov, bz, er,
                    input bit en, cl, input logic [2:0] opc);
    exp_ctl = {cr, ir, ov, bz, er, en, cl, opc};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // compare process + behavioural MACC accumulator
  always @(negedge clk) begin
    logic [AW-1:0] prod;
    if (chk_en) begin
      check("ctl", {54'd0, cfg_ready, in_ready, out_valid,
                    busy, err, macc_enable, macc_clear,
                    macc_op_code}, {54'd0, exp_ctl});
      if (macc_clear) acc = '0;
      if (macc_enable) begin
        check("ops", {macc_op_add, macc_op_0, macc_op_1},
              {exp_bias, in_op_0, in_op_1});
        if (macc_op_code[0])
          prod = AW'(macc_op_0) * AW'(macc_op_0);
        else
          prod = AW'(macc_op_0) * AW'(macc_op_1);
        if (macc_op_code[1])
          acc = acc + prod;
        else
          acc = (macc_op_code[2] ? macc_op_add : '0) + prod;
      end
      if (out_valid && res_en)
        check("result", 64'(acc), 64'(exp_res));
    end
  end

  task automatic idle_in();
    cfg_valid = 0; in_valid = 0;
    out_ready = 0; abort = 0;
  endtask

  task automatic run_job(input int len, input bit sq,
                         input bit be, input logic [AW-1:0] bias,
                         input int gap, input int owait,
                         input int abort_i, input bit rst_drain,
                         input logic [AW-1:0] lit);
    logic [AW-1:0] s;
    logic [2:0] opc;
    s = be ? bias : '0;
    for (int i = 0; i < len; i++)
      s += sq ? AW'(a[i]) * AW'(a[i])
              : AW'(a[i]) * AW'(b[i]);
    exp_res = s;
    exp_bias = bias;
    cfg_valid = 1; cfg_len = LW'(len);
    cfg_square = sq; cfg_bias_en = be; cfg_bias = bias;
    ex(1, 0, 0, 0, 0, 0, 0, 3'b000);
    tick();
    cfg_valid = 0;
    if (len == 0) begin
      ex(1, 0, 0, 0, 1, 0, 0, 3'b000);
      tick();
      ex(1, 0, 0, 0, 0, 0, 0, 3'b000);
      tick();
      return;
    end
    for (int i = 0; i < len; i++) begin
      opc = (i == 0) ? {be, 1'b0, sq} : {1'b0, 1'b1, sq};
      for (int g = 0; g < gap; g++) begin
        in_valid = 0;
        ex(0, 1, 0, 1, 0, 0, 0, opc);
        tick();
      end
      in_valid = 1; in_op_0 = a[i]; in_op_1 = b[i];
      if (i == abort_i) begin
        abort = 1;
        ex(0, 0, 0, 1, 0, 0, 0, opc);
        tick();
        abort = 0; in_valid = 0;
        ex(0, 0, 0, 1, 0, 0, 1, 3'b000);
        tick();
        ex(0, 0, 0, 1, 0, 0, 0, 3'b000);
        tick();
        tick();
        ex(1, 0, 0, 0, 0, 0, 0, 3'b000);
        tick();
        return;
      end
      ex(0, 1, 0, 1, 0, 1, 0, opc);
      tick();
    end
    in_valid = 0;
    if (rst_drain) begin
      ex(1, 0, 0, 0, 0, 0, 0, 3'b000);
      #1 reset = 1;
      tick();
      tick();
      reset = 0;
      for (int k = 0; k < 5; k++) tick();
      return;
    end
    ex(0, 0, 0, 1, 0, 0, 0, 3'b000);
    tick();
    tick();
    res_en = 1;
    for (int w = 0; w < owait; w++) begin
      ex(0, 0, 1, 1, 0, 0, 0, 3'b000);
      tick();
    end
    out_ready = 1;
    ex(0, 0, 1, 1, 0, 0, 0, 3'b000);
    tick();
    out_ready = 0; res_en = 0;
    check("result_lit", 64'(acc), 64'(lit));
    ex(1, 0, 0, 0, 0, 0, 0, 3'b000);
    tick();
  endtask

  initial begin
    reset = 1;
    idle_in();
    cfg_len = '0; cfg_square = 0;
    cfg_bias_en = 0; cfg_bias = '0;
    in_op_0 = '0; in_op_1 = '0;
    exp_bias = '0; exp_res = '0;
    ex(1, 0, 0, 0, 0, 0, 0, 3'b000);
    chk_en = 1;
    tick();
    tick();
    reset = 0;
    tick();

    // plain 3-element dot product: 12+30+56
    a = '{3, 5, 7, 0, 0, 0, 0, 0};
    b = '{4, 6, 8, 0, 0, 0, 0, 0};
    run_job(3, 0, 0, '0, 0, 0, -1, 0, 32'd98);

    // squares with bias, result held 4 cycles: 5+9+16
    a = '{3, 4, 0, 0, 0, 0, 0, 0};
    b = '{100, 200, 0, 0, 0, 0, 0, 0};
    run_job(2, 1, 1, 32'd5, 0, 4, -1, 0, 32'd30);

    // gapped vs gapless: 10+40+90+160
    a = '{1, 2, 3, 4, 0, 0, 0, 0};
    b = '{10, 20, 30, 40, 0, 0, 0, 0};
    run_job(4, 0, 0, '0, 2, 1, -1, 0, 32'd300);
    run_job(4, 0, 0, '0, 0, 0, -1, 0, 32'd300);

    // zero-length job
    run_job(0, 0, 1, 32'd7, 0, 0, -1, 0, '0);

    // abort in idle is ignored
    abort = 1;
    ex(1, 0, 0, 0, 0, 0, 0, 3'b000);
    tick();
    abort = 0;
    tick();

    // abort on 2nd element, then clean 1-element job
    a = '{2, 3, 4, 5, 0, 0, 0, 0};
    b = '{2, 3, 4, 5, 0, 0, 0, 0};
    run_job(4, 0, 1, 32'd1000, 0, 0, 1, 0, '0);
    a = '{9, 0, 0, 0, 0, 0, 0, 0};
    b = '{10, 0, 0, 0, 0, 0, 0, 0};
    run_job(1, 0, 0, '0, 0, 2, -1, 0, 32'd90);

    // async reset while draining
    a = '{6, 7, 0, 0, 0, 0, 0, 0};
    b = '{6, 7, 0, 0, 0, 0, 0, 0};
    run_job(2, 0, 0, '0, 0, 0, -1, 1, '0);

    // config after reset starts cleanly: bias 3 + 2*5
    a = '{2, 0, 0, 0, 0, 0, 0, 0};
    b = '{5, 0, 0, 0, 0, 0, 0, 0};
    run_job(1, 0, 1, 32'd3, 0, 0, -1, 0, 32'd13);

    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
